// File: rtl/pc_fetch_ctrl_if.sv
// Fetch-side bus of the PC sequencer: adder feedback, downstream handshake,
// redirect/trap requests and the registered PC/status outputs.
interface pc_fetch_ctrl_if;
   logic [31:0] pc_plus4_in;
   logic        fetch_ready;
   logic        redirect_valid;
   logic [31:0] redirect_target;
   logic        trap;
   logic [31:0] pc_out;
   logic        fetch_valid;
   logic        misaligned;
   logic [31:0] fetch_count;

   // The sequencer owns the PC and status outputs.
   modport master (
      input  pc_plus4_in,
      input  fetch_ready,
      input  redirect_valid,
      input  redirect_target,
      input  trap,
      output pc_out,
      output fetch_valid,
      output misaligned,
      output fetch_count
   );

   // Surrounding core: adder, imem/decode, execute and trap logic.
   modport slave (
      output pc_plus4_in,
      output fetch_ready,
      output redirect_valid,
      output redirect_target,
      output trap,
      input  pc_out,
      input  fetch_valid,
      input  misaligned,
      input  fetch_count
   );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// PC register and fetch sequencer. One BOOT cycle after reset, then RUN
// advances the PC through the external pc_plus4 adder on each accepted fetch.
// Misaligned redirects park the block in FAULT until a trap arrives.
module pc_fetch_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
   input logic            clk,
   input logic            rst_n,
   pc_fetch_ctrl_if.master bus
);

   typedef enum logic [1:0] {
      StBoot  = 2'd0,
      StRun   = 2'd1,
      StFault = 2'd2
   } state_e;

   state_e state;
   logic   fire;
   logic   target_aligned;

   // Accepted fetch and redirect alignment, both from registered/input values only.
   always_comb begin
      fire           = bus.fetch_valid & bus.fetch_ready;
      target_aligned = (bus.redirect_target[1:0] == 2'b00);
   end

   // Sequencer: state, PC, status flags and fetch counter all registered here,
   // so no input reaches an output without passing through a flop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= StBoot;
         bus.pc_out      <= RESET_PC;
         bus.fetch_valid <= 1'b0;
         bus.misaligned  <= 1'b0;
         bus.fetch_count <= 32'd0;
      end else if (bus.trap) begin
         // Trap wins in every state and kills any same-cycle redirect or fire.
         state           <= StRun;
         bus.pc_out      <= TRAP_VEC;
         bus.fetch_valid <= 1'b1;
         bus.misaligned  <= 1'b0;
      end else begin
         unique case (state)
            StBoot: begin
               // Redirects are meaningless before the first fetch.
               state           <= StRun;
               bus.fetch_valid <= 1'b1;
               bus.misaligned  <= 1'b0;
            end
            StRun: begin
               if (bus.redirect_valid && target_aligned) begin
                  bus.pc_out <= bus.redirect_target;
               end else if (bus.redirect_valid) begin
                  // Keep the PC of the faulting fetch for the trap handler.
                  state           <= StFault;
                  bus.fetch_valid <= 1'b0;
                  bus.misaligned  <= 1'b1;
               end else if (fire) begin
                  // Adder result wraps modulo 2^32 by construction.
                  bus.pc_out      <= bus.pc_plus4_in;
                  bus.fetch_count <= bus.fetch_count + 32'd1;
               end
            end
            StFault: begin
               // Frozen until trap; redirect and fetch_ready are ignored.
               bus.fetch_valid <= 1'b0;
               bus.misaligned  <= 1'b1;
            end
            default: begin
               state           <= StBoot;
               bus.fetch_valid <= 1'b0;
               bus.misaligned  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl with a behavioural reference model and
// literal checkpoints from the test plan.
module tb_pc_fetch_ctrl;
   localparam logic [31:0] RST_PC = 32'h0000_1000;
   localparam logic [31:0] TRP_PC = 32'h0000_0100;

   logic clk;
   logic rst_n;
   int   errors = 0;
   int   checks = 0;

   pc_fetch_ctrl_if bus ();

   pc_fetch_ctrl #(
      .RESET_PC (RST_PC),
      .TRAP_VEC (TRP_PC)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // External adder closing the PC loop.
   assign bus.pc_plus4_in = bus.pc_out + 32'd4;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: what the architectural PC, validity, fault flag and
   // fetch count must be.
   logic [31:0] m_pc = RST_PC;
   logic        m_booting = 1'b1;
   logic        m_valid = 1'b0;
   logic        m_fault = 1'b0;
   logic [31:0] m_cnt = 32'd0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_pc <= RST_PC; m_booting <= 1'b1; m_valid <= 1'b0; m_fault <= 1'b0; m_cnt <= 32'd0;
      end else if (bus.trap) begin
         m_pc <= TRP_PC; m_booting <= 1'b0; m_valid <= 1'b1; m_fault <= 1'b0;
      end else if (m_booting) begin
         m_booting <= 1'b0; m_valid <= 1'b1;
      end else if (m_valid) begin
         if (bus.redirect_valid) begin
            if (bus.redirect_target % 4 == 0) m_pc <= bus.redirect_target;
            else begin
               m_valid <= 1'b0; m_fault <= 1'b1;
            end
         end else if (bus.fetch_ready) begin
            m_pc  <= m_pc + 32'd4;
            m_cnt <= m_cnt + 32'd1;
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %h want %h at %0t", name, got, want, $time);
      end
   endtask

   // Every-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      chk("model_pc", bus.pc_out, m_pc);
      chk("model_valid", {31'd0, bus.fetch_valid}, {31'd0, m_valid});
      chk("model_misaligned", {31'd0, bus.misaligned}, {31'd0, m_fault});
      chk("model_count", bus.fetch_count, m_cnt);
   end

   task automatic drive(input logic rdy, input logic rv, input logic [31:0] tgt,
                        input logic tr);
      bus.fetch_ready     = rdy;
      bus.redirect_valid  = rv;
      bus.redirect_target = tgt;
      bus.trap            = tr;
   endtask

   // Advance one cycle: wait for the next falling edge, then apply new inputs.
   task automatic cyc(input logic rdy, input logic rv, input logic [31:0] tgt,
                      input logic tr);
      @(negedge clk);
      drive(rdy, rv, tgt, tr);
   endtask

   initial begin
      rst_n = 1'b0;
      drive(1'b0, 1'b0, 32'd0, 1'b0);
      repeat (2) @(negedge clk);
      chk("rst_pc", bus.pc_out, 32'h1000);
      chk("rst_valid", {31'd0, bus.fetch_valid}, 32'd0);

      // Reset release and boot with ready held high.
      drive(1'b1, 1'b0, 32'd0, 1'b0);
      #1 rst_n = 1'b1;
      #1 chk("boot_pc", bus.pc_out, 32'h1000);
      chk("boot_valid", {31'd0, bus.fetch_valid}, 32'd0);
      @(negedge clk);
      chk("run0_pc", bus.pc_out, 32'h1000);
      chk("run0_valid", {31'd0, bus.fetch_valid}, 32'd1);
      chk("run0_cnt", bus.fetch_count, 32'd0);
      @(negedge clk);
      chk("run1_pc", bus.pc_out, 32'h1004);
      chk("run1_cnt", bus.fetch_count, 32'd1);
      @(negedge clk);
      chk("run2_pc", bus.pc_out, 32'h1008);
      chk("run2_cnt", bus.fetch_count, 32'd2);

      // Backpressure for three cycles at 0x1008.
      drive(1'b0, 1'b0, 32'd0, 1'b0);
      repeat (3) @(negedge clk);
      chk("bp_pc", bus.pc_out, 32'h1008);
      chk("bp_cnt", bus.fetch_count, 32'd2);
      drive(1'b1, 1'b0, 32'd0, 1'b0);
      @(negedge clk);
      chk("bp_release_pc", bus.pc_out, 32'h100C);
      chk("bp_release_cnt", bus.fetch_count, 32'd3);

      // Redirect with and without ready.
      drive(1'b0, 1'b1, 32'h2000, 1'b0);
      @(negedge clk);
      chk("redir_nordy_pc", bus.pc_out, 32'h2000);
      chk("redir_nordy_cnt", bus.fetch_count, 32'd3);
      drive(1'b1, 1'b1, 32'h2000, 1'b0);
      @(negedge clk);
      chk("redir_rdy_pc", bus.pc_out, 32'h2000);
      chk("redir_rdy_cnt", bus.fetch_count, 32'd3);

      // Misaligned redirect, then attempts to move out of FAULT.
      drive(1'b1, 1'b1, 32'h2002, 1'b0);
      @(negedge clk);
      chk("fault_pc", bus.pc_out, 32'h2000);
      chk("fault_mis", {31'd0, bus.misaligned}, 32'd1);
      chk("fault_valid", {31'd0, bus.fetch_valid}, 32'd0);
      drive(1'b1, 1'b1, 32'h3000, 1'b0);
      cyc(1'b1, 1'b0, 32'd0, 1'b0);
      @(negedge clk);
      chk("fault_hold_pc", bus.pc_out, 32'h2000);
      chk("fault_hold_mis", {31'd0, bus.misaligned}, 32'd1);
      chk("fault_hold_cnt", bus.fetch_count, 32'd3);
      drive(1'b0, 1'b0, 32'd0, 1'b1);
      @(negedge clk);
      chk("trap_exit_pc", bus.pc_out, 32'h0100);
      chk("trap_exit_mis", {31'd0, bus.misaligned}, 32'd0);
      chk("trap_exit_valid", {31'd0, bus.fetch_valid}, 32'd1);

      // Trap + redirect + fire in one cycle.
      drive(1'b1, 1'b1, 32'h3000, 1'b1);
      @(negedge clk);
      chk("prio_pc", bus.pc_out, 32'h0100);
      chk("prio_cnt", bus.fetch_count, 32'd3);

      // Wrap-around through the adder.
      drive(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0);
      @(negedge clk);
      chk("wrap_redir_pc", bus.pc_out, 32'hFFFF_FFFC);
      drive(1'b1, 1'b0, 32'd0, 1'b0);
      @(negedge clk);
      chk("wrap_pc", bus.pc_out, 32'h0000_0000);
      chk("wrap_mis", {31'd0, bus.misaligned}, 32'd0);
      chk("wrap_cnt", bus.fetch_count, 32'd4);
      @(negedge clk);
      chk("wrap_next_pc", bus.pc_out, 32'h0000_0004);

      // Asynchronous reset between clock edges.
      #2 rst_n = 1'b0;
      #1 chk("arst_pc", bus.pc_out, 32'h1000);
      chk("arst_valid", {31'd0, bus.fetch_valid}, 32'd0);
      chk("arst_mis", {31'd0, bus.misaligned}, 32'd0);
      chk("arst_cnt", bus.fetch_count, 32'd0);

      // Trap during the BOOT cycle is honoured.
      @(negedge clk);
      drive(1'b0, 1'b1, 32'h4000, 1'b1);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("boot_trap_pc", bus.pc_out, 32'h0100);
      chk("boot_trap_valid", {31'd0, bus.fetch_valid}, 32'd1);
      drive(1'b1, 1'b0, 32'd0, 1'b0);
      repeat (2) @(negedge clk);
      chk("boot_trap_adv_pc", bus.pc_out, 32'h0108);

      #1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
